shift_frame_ctrl: RTL



---
 rtl/shift_defs.sv | 12 +
 rtl/shift_chain.sv | 40 ++++
 rtl/shift_frame_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/shift_defs.sv
// Shared definitions for the serial shift-chain sequencer: FSM state encoding
// and the default frame width.
package shift_defs;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/shift_chain.sv
// WIDTH-bit parallel-in/serial-out register, MSB first. A synchronous clear
// wins over load, and load wins over shift.
module shift_chain
  import shift_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic             q_msb
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // NOTE: assign a default before any branch so always_comb can never infer a latch.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = d;
    end else if (shift_en) begin
      data_d = {data_q[WIDTH-2:0], 1'b0};
    end
  end

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_msb = data_q[WIDTH-1];

endmodule

// File: rtl/shift_frame_ctrl.sv
// Accepts a parallel word over valid/ready and serializes it MSB-first, with
// stall, frame strobe, done pulse and gap-free back-to-back frames.
module shift_frame_ctrl
  import shift_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ser_stall,
  output logic             ser_out,
  output logic             frame,
  output logic             done,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             load;
  logic             shift_en;
  logic             chain_msb;
  logic             in_shift;
  logic             last_bit;
  logic             accept;

  assign in_shift = (state_q == ST_SHIFT);
  // The last bit only "completes" on a cycle it is not stalled.
  assign last_bit = in_shift && (cnt_q == LAST_CNT) && !ser_stall;
  assign in_ready = !clr && ((state_q == ST_IDLE) || last_bit);
  assign accept   = in_valid && in_ready;
  assign done     = last_bit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          cnt_d = '0;
          if (accept) begin
            load = 1'b1;
          end else begin
            // Flush the final bit so the register is empty while idle.
            shift_en = 1'b1;
            state_d  = ST_IDLE;
          end
        end else if (!ser_stall) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  shift_chain #(
    .WIDTH(WIDTH)
  ) u_chain (
    .clk     (clk),
    .clr     (clr),
    .load    (load),
    .shift_en(shift_en),
    .d       (in_data),
    .q_msb   (chain_msb)
  );

  assign busy    = in_shift;
  assign frame   = in_shift;
  assign ser_out = in_shift && chain_msb;

endmodule
